tone_sequencer: RTL and testbench

Programmable tone-sequence controller for the sine generator. It holds a small table of (phase increment, duration) entries and plays them in order by driving the generator's `en` and `incr` inputs cycle by cycle. Optional silent gaps separate tones, and the sequence can loop. The block sits between the control/top level and `sinegen`; its `en`/`incr` outputs connect directly to the generator.

---
 rtl/tone_sequencer.sv | 129 ++++++++++++
 tb/tb_tone_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Tone-sequence controller: plays a table of (increment, duration) entries into the
// sine generator's en/incr inputs, with optional silent gaps and looping.
module tone_sequencer #(
  parameter int D_WIDTH   = 8,
  parameter int DUR_WIDTH = 16,
  parameter int DEPTH     = 8,
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_addr,
  input  logic [D_WIDTH-1:0]   wr_incr,
  input  logic [DUR_WIDTH-1:0] wr_dur,
  input  logic [IW:0]          num_tones,
  input  logic [DUR_WIDTH-1:0] gap_len,
  input  logic                 loop,
  input  logic                 start,
  input  logic                 stop,
  output logic                 en,
  output logic [D_WIDTH-1:0]   incr,
  output logic                 busy,
  output logic [IW-1:0]        tone_idx,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  logic [D_WIDTH-1:0]   tbl_incr [DEPTH];
  logic [DUR_WIDTH-1:0] tbl_dur  [DEPTH];

  state_t               state;
  logic [IW:0]          cnt;
  logic [DUR_WIDTH-1:0] gap;
  logic                 lp;
  logic [DUR_WIDTH-1:0] ctr;

  logic [IW:0]          cnt_clamp;
  logic [IW:0]          nxt_w;
  logic                 last;
  logic [IW-1:0]        nxt_idx;
  logic [DUR_WIDTH-1:0] nxt_dur;
  logic [DUR_WIDTH-1:0] dur0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_incr[i] <= '0;
        tbl_dur[i]  <= '0;
      end
    end else if (wr_en) begin
      tbl_incr[wr_addr] <= wr_incr;
      tbl_dur[wr_addr]  <= wr_dur;
    end
  end

  // Index arithmetic is one bit wider than the table index so idx+1 never wraps.
  always_comb begin
    cnt_clamp = (num_tones > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : num_tones;
    nxt_w     = {1'b0, tone_idx} + 1'b1;
    last      = (nxt_w >= cnt);
    nxt_idx   = last ? '0 : nxt_w[IW-1:0];
    nxt_dur   = (tbl_dur[nxt_idx] == '0) ? DUR_WIDTH'(1) : tbl_dur[nxt_idx];
    dur0      = (tbl_dur[0] == '0) ? DUR_WIDTH'(1) : tbl_dur[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      en       <= 1'b0;
      incr     <= '0;
      busy     <= 1'b0;
      tone_idx <= '0;
      done     <= 1'b0;
      ctr      <= '0;
      cnt      <= '0;
      gap      <= '0;
      lp       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        en    <= 1'b0;
        incr  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && cnt_clamp != '0) begin
              cnt      <= cnt_clamp;
              gap      <= gap_len;
              lp       <= loop;
              state    <= PLAY;
              en       <= 1'b1;
              busy     <= 1'b1;
              incr     <= tbl_incr[0];
              ctr      <= dur0;
              tone_idx <= '0;
            end
          end
          default: begin
            if (ctr > DUR_WIDTH'(1)) begin
              ctr <= ctr - 1'b1;
            end else if (state == PLAY && gap != '0 && (!last || lp)) begin
              // gap between tones and at the loop wrap, never after the final tone
              state <= GAP;
              en    <= 1'b0;
              incr  <= '0;
              ctr   <= gap;
            end else if (!last || lp) begin
              state    <= PLAY;
              en       <= 1'b1;
              incr     <= tbl_incr[nxt_idx];
              ctr      <= nxt_dur;
              tone_idx <= nxt_idx;
            end else begin
              state <= IDLE;
              en    <= 1'b0;
              incr  <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus random tables/sequences, checked
// cycle by cycle against an expected output trace built from the table contents.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_incr = '0;
  logic [15:0] wr_dur = '0;
  logic [3:0]  num_tones = '0;
  logic [15:0] gap_len = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        en;
  logic [7:0]  incr;
  logic        busy;
  logic [2:0]  tone_idx;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  int m_incr [8];
  int m_dur  [8];
  int q_en [$];
  int q_incr [$];
  int q_idx [$];

  tone_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_incr(wr_incr),
    .wr_dur(wr_dur), .num_tones(num_tones), .gap_len(gap_len), .loop(loop),
    .start(start), .stop(stop), .en(en), .incr(incr), .busy(busy),
    .tone_idx(tone_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int inc, input int d);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_incr = inc[7:0]; wr_dur = d[15:0];
    @(posedge clk); #1 wr_en = 1'b0;
    m_incr[a] = inc; m_dur[a] = d;
  endtask

  // Expected en/incr/tone_idx per cycle after start. An entry's increment is taken
  // when the entry begins; a pending write to entry wa lands after cycle wr_at.
  task automatic build(input int c, input int gp, input bit lp, input int maxc,
                       input int wr_at, input int wa, input int wi);
    int i, v, d;
    q_en.delete(); q_incr.delete(); q_idx.delete();
    i = 0;
    while (c > 0) begin
      v = (i == wa && wr_at >= 0 && q_en.size() > wr_at + 1) ? wi : m_incr[i];
      d = (m_dur[i] == 0) ? 1 : m_dur[i];
      repeat (d) begin q_en.push_back(1); q_incr.push_back(v); q_idx.push_back(i); end
      if (i == c - 1 && !lp) break;
      repeat (gp) begin q_en.push_back(0); q_incr.push_back(0); q_idx.push_back(i); end
      i = (i == c - 1) ? 0 : i + 1;
      if (lp && q_en.size() >= maxc) break;
    end
  endtask

  task automatic play(input int nt, input int gp, input bit lp, input int maxc,
                      input int stop_at, input int rs_at, input int wr_at,
                      input int wa, input int wi);
    int c;
    c = (nt > 8) ? 8 : nt;
    build(c, gp, lp, maxc, wr_at, wa, wi);
    num_tones = nt[3:0]; gap_len = gp[15:0]; loop = lp;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (c == 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("idle_busy", k, busy, 0);
        chk("idle_done", k, done, 0);
        chk("idle_en", k, en, 0);
      end
      return;
    end
    for (int k = 0; k < q_en.size(); k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      chk("en", k, en, q_en[k]);
      chk("incr", k, incr, q_incr[k]);
      chk("tone_idx", k, tone_idx, q_idx[k]);
      chk("busy", k, busy, 1);
      chk("done_low", k, done, 0);
      if (k == rs_at) start = 1'b1;
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = wa[2:0]; wr_incr = wi[7:0]; wr_dur = m_dur[wa][15:0];
      end
      if (k == stop_at) begin
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0; start = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("stop_en", k, en, 0);
        chk("stop_busy", k, busy, 0);
        chk("stop_incr", k, incr, 0);
        chk("stop_done", k, done, 0);
        @(negedge clk);
        chk("stop_done2", k, done, 0);
        if (wr_at >= 0) m_incr[wa] = wi;
        return;
      end
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (wr_at >= 0) m_incr[wa] = wi;
    chk("done", q_en.size(), done, 1);
    chk("end_busy", q_en.size(), busy, 0);
    chk("end_en", q_en.size(), en, 0);
    @(negedge clk);
    chk("done_pulse", q_en.size() + 1, done, 0);
  endtask

  initial begin
    int nt, gp, mc;
    bit lp;
    for (int i = 0; i < 8; i++) begin m_incr[i] = 0; m_dur[i] = 0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_en", 0, en, 0);
    chk("rst_incr", 0, incr, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_idx", 0, tone_idx, 0);
    chk("rst_done", 0, done, 0);

    wr(0, 4, 3);
    wr(1, 9, 2);
    play(2, 0, 0, 0, -1, -1, -1, 0, 0);          // two tones, no gap
    play(2, 2, 0, 0, -1, -1, -1, 0, 0);          // gap between tones only
    play(2, 1, 1, 20, 17, 2, -1, 0, 0);          // loop, start while busy, stop
    play(0, 0, 0, 0, -1, -1, -1, 0, 0);          // zero count ignored
    wr(2, 5, 0);
    play(3, 0, 0, 0, -1, -1, -1, 0, 0);          // dur 0 plays one cycle

    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("ss_busy", 0, busy, 0);
    chk("ss_en", 0, en, 0);

    play(2, 1, 1, 14, 13, -1, 1, 0, 7);          // rewrite entry 0 while it plays
    play(12, 1, 0, 0, -1, -1, -1, 0, 0);         // count clamps to DEPTH

    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 8; a++) wr(a, $urandom_range(255, 0), $urandom_range(4, 0));
      nt = $urandom_range(11, 0);
      gp = $urandom_range(3, 0);
      lp = 1'($urandom_range(1, 0));
      mc = $urandom_range(40, 10);
      play(nt, gp, lp, mc, lp ? mc - 1 : -1, -1, -1, 0, 0);
    end

    num_tones = 4'd3; gap_len = '0; loop = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_en", 0, en, 0);
    chk("mrst_incr", 0, incr, 0);
    chk("mrst_busy", 0, busy, 0);
    chk("mrst_idx", 0, tone_idx, 0);
    chk("mrst_done", 0, done, 0);
    for (int i = 0; i < 8; i++) begin m_incr[i] = 0; m_dur[i] = 0; end
    play(3, 0, 0, 0, -1, -1, -1, 0, 0);          // cleared table: 1 cycle per entry

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
